// File: rtl/nibble_serial_adder32.sv
// nibble_serial_adder32: 32-bit add/subtract built from one 4-bit carry-lookahead
// slice reused across all nibbles, least significant nibble first, one per clock.
// Each nibble's group generate/propagate (GG/GP) forms the carry into the next nibble.
module nibble_serial_adder32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             zero
);

    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [IDXW-1:0]  idx_reg;
    logic             c_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work_reg;

    // Operand nibbles that feed the slice, selected by the current nibble index.
    logic [3:0] a_nib;
    logic [3:0] b_nib;
    assign a_nib = a_reg[{idx_reg, 2'b00} +: 4];
    assign b_nib = b_reg[{idx_reg, 2'b00} +: 4];

    // 4-bit carry-lookahead slice: per-bit propagate/generate, lookahead carries,
    // then the group terms that pass the carry on to the next nibble.
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] carry;
    logic [3:0] nib_sum;
    logic       gp;
    logic       gg;
    logic       c_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign p[gi]       = a_nib[gi] ^ b_nib[gi];
            assign g[gi]       = a_nib[gi] & b_nib[gi];
            assign nib_sum[gi] = p[gi] ^ carry[gi];
        end
    endgenerate

    assign carry[0] = c_reg;
    assign carry[1] = g[0] | (p[0] & c_reg);
    assign carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_reg);
    assign carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c_reg);

    assign gp     = p[3] & p[2] & p[1] & p[0];
    assign gg     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
    assign c_next = gg | (gp & c_reg);

    // Complete result as it will look once the current nibble has been written;
    // used at the final nibble so s/zero/ov are loaded in the same edge.
    logic [WIDTH-1:0] final_sum;
    always_comb begin
        final_sum = work_reg;
        final_sum[{idx_reg, 2'b00} +: 4] = nib_sum;
    end

    // Sequencer: accepts an operation, walks the nibbles, and loads the
    // registered result flags on the last nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            c_reg     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
            ov        <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry.
                        a_reg     <= a;
                        b_reg     <= b ^ {WIDTH{sub}};
                        c_reg     <= sub;
                        idx_reg   <= '0;
                        work_reg  <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    work_reg[{idx_reg, 2'b00} +: 4] <= nib_sum;
                    c_reg   <= c_next;
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        s         <= final_sum;
                        co        <= c_next;
                        ov        <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                                   & (final_sum[WIDTH-1] != a_reg[WIDTH-1]);
                        zero      <= (final_sum == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder32.sv
// Testbench for nibble_serial_adder32: directed and random operations, with
// expected results queued at acceptance and checked by an independent monitor.
module tb_nibble_serial_adder32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        zero;

    nibble_serial_adder32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ov    (ov),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        zero;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          edge_no = 0;
    int          rem = 0;
    logic [31:0] held_s = '0;
    logic        held_co = 1'b0;
    logic        held_ov = 1'b0;
    logic        held_zero = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, req, edge_no);
        end
    endtask

    // Reference arithmetic: unsigned result, unsigned no-borrow, signed range test.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic op_sub);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      r;
        logic [32:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = op_sub ? (sx - sy) : (sx + sy);
        u  = op_sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        e.s    = u[31:0];
        e.co   = op_sub ? (x >= y) : u[32];
        e.ov   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.zero = (u[31:0] == 32'd0);
        e.due  = 0;
        return e;
    endfunction

    // Acceptance model: a start is taken only when no operation is in flight;
    // the result is due eight edges after the accepting edge.
    always @(posedge clk) begin
        exp_t e;
        edge_no++;
        if (!rst_n) begin
            rem = 0;
        end else if (rem == 0 && start) begin
            e = model(a, b, sub);
            e.due = edge_no + 8;
            q.push_back(e);
            rem = 8;
        end else if (rem > 0) begin
            rem--;
        end
    end

    // Monitor: checks busy/done timing every cycle and the held result outputs.
    always @(negedge clk) begin
        exp_t e;
        logic exp_done;
        if (rst_n) begin
            exp_done = (q.size() > 0) && (q[0].due == edge_no);
            chk("done", {31'd0, done}, {31'd0, exp_done});
            chk("busy", {31'd0, busy}, {31'd0, (rem != 0)});
            if (exp_done) begin
                e = q.pop_front();
                held_s    = e.s;
                held_co   = e.co;
                held_ov   = e.ov;
                held_zero = e.zero;
                $display("result s=%h co=%0b ov=%0b zero=%0b (dut s=%h co=%0b ov=%0b zero=%0b)",
                         e.s, e.co, e.ov, e.zero, s, co, ov, zero);
            end
            chk("s", s, held_s);
            chk("co", {31'd0, co}, {31'd0, held_co});
            chk("ov", {31'd0, ov}, {31'd0, held_ov});
            chk("zero", {31'd0, zero}, {31'd0, held_zero});
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_s"}, s, 32'd0);
        chk({tag, "_co"}, {31'd0, co}, 32'd0);
        chk({tag, "_ov"}, {31'd0, ov}, 32'd0);
        chk({tag, "_zero"}, {31'd0, zero}, 32'd0);
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic op_sub);
        @(negedge clk);
        a = x; b = y; sub = op_sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    logic [31:0] dir_a[7] = '{32'h0000000F, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                              32'h00000005, 32'h00000007, 32'hFFFFFFFF};
    logic [31:0] dir_b[7] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001,
                              32'h00000007, 32'h00000007, 32'hFFFFFFFF};
    logic        dir_sub[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed cases from the corner list.
        for (int i = 0; i < 7; i++) do_op(dir_a[i], dir_b[i], dir_sub[i]);

        // Starts during RUN are ignored; only the first operation completes.
        @(negedge clk);
        a = 32'h00001234; b = 32'h00000101; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); a = 32'hDEADBEEF; b = 32'h12345678; sub = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); a = 32'h0BADF00D; b = 32'h0000FFFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);

        // Continuous start with changing operands: back-to-back acceptance.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        // Random isolated operations.
        for (int i = 0; i < 30; i++) begin
            do_op($urandom, (i % 5 == 0) ? 32'd0 : $urandom, $urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of an operation: no done, outputs cleared at once.
        @(negedge clk);
        a = 32'hFFFF0000; b = 32'h0000FFFF; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        q.delete();
        held_s = '0; held_co = 1'b0; held_ov = 1'b0; held_zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_op(32'h12345678, 32'h11111111, 1'b0);
        chk("post_reset_sum", s, 32'h23456789);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
